// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: access-size
// encodings, FSM state type, wait-state range and the alignment rule.
package dmem_responder_pkg;

  // size_i encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Largest wait-state count the 4-bit counter can hold
  localparam int WAIT_CYC_MAX = 15;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmemState_e;

  // An access is illegal when its low address bits do not match its natural
  // alignment, or when the reserved size code is used.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering for the data memory: merges store data
// into the addressed lanes of the old word, and extracts/extends load data.
// Any size other than byte/half is handled as a full word.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign,
  output logic [31:0] newWord,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Store merge: only the addressed lanes change, the rest keep old contents
  always_comb begin
    newWord = oldWord;
    case (size)
      SZ_BYTE: newWord[{lane, 3'b000} +: 8]      = wdata[7:0];
      SZ_HALF: newWord[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: newWord = wdata;
    endcase
  end

  // Load extract: right-align the selected lanes, then sign/zero extend
  always_comb begin
    byteSel = oldWord[{lane, 3'b000} +: 8];
    halfSel = oldWord[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: loadData = {{24{sign & byteSel[7]}}, byteSel};
      SZ_HALF: loadData = {{16{sign & halfSel[15]}}, halfSel};
      default: loadData = oldWord;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS MEM stage. Word-organised
// RAM with a programmable number of wait states; the pipeline is stalled
// until the access commits on the edge that enters DONE.
// Optional: define DMEM_ALIGN_CHECK_EN to enable misalignment/illegal-size
// detection on err_o; when undefined err_o is 0 and low address bits are
// forced to the natural alignment of the access (reserved size = word).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  // Out-of-range wait counts are clamped to what the counter can hold
  localparam int WaitEff = (WAIT_CYC > WAIT_CYC_MAX) ? WAIT_CYC_MAX :
                           ((WAIT_CYC < 0) ? 0 : WAIT_CYC);
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'((WaitEff > 0) ? WaitEff - 1 : 0);

  dmemState_e         state;
  dmemState_e         stateNxt;
  logic [CNT_W-1:0]   waitCnt;
  logic               commit;

  logic [31:0]        mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0]  wordIdx;
  logic [31:0]        oldWord;
  logic [31:0]        newWord;
  logic [31:0]        loadData;
  logic [1:0]         sizeEff;
  logic [1:0]         laneEff;
  logic               accErr;
  logic               unusedAddrHi;

  // Upper address bits wrap around the RAM and are intentionally ignored
  assign wordIdx      = addr_i[ADDR_W+1:2];
  assign unusedAddrHi = ^addr_i[31:ADDR_W+2];
  assign oldWord      = mem[wordIdx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign sizeEff = size_i;
  assign laneEff = addr_i[1:0];
  assign accErr  = isMisaligned(size_i, addr_i[1:0]);
`else
  // Without checking, force natural alignment and treat reserved size as word
  always_comb begin
    sizeEff = (size_i == SZ_RSVD) ? SZ_WORD : size_i;
    case (sizeEff)
      SZ_BYTE: laneEff = addr_i[1:0];
      SZ_HALF: laneEff = {addr_i[1], 1'b0};
      default: laneEff = 2'b00;
    endcase
  end
  assign accErr = 1'b0;
`endif

  dmem_lane_align uAlign (
    .oldWord  (oldWord),
    .wdata    (wdata_i),
    .size     (sizeEff),
    .lane     (laneEff),
    .sign     (sign_i),
    .newWord  (newWord),
    .loadData (loadData)
  );

  // Stall until the access reaches DONE; reset releases the pipeline at once
  assign stall_o = ~rst & req_i & (state != ST_DONE);

  // Next-state logic; commit marks the edge that enters DONE
  always_comb begin
    stateNxt = state;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_i) begin
          if (WaitEff == 0) begin
            stateNxt = ST_DONE;
            commit   = 1'b1;
          end else begin
            stateNxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          // Pipeline flush: abandon the access without side effects
          stateNxt = ST_IDLE;
        end else if (waitCnt == '0) begin
          stateNxt = ST_DONE;
          commit   = 1'b1;
        end
      end
      ST_DONE: stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  // State register and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      state <= stateNxt;
      if (state == ST_IDLE && req_i) begin
        waitCnt <= CntLoad;
      end else if (state == ST_WAIT && waitCnt != '0) begin
        waitCnt <= waitCnt - CNT_W'(1);
      end
    end
  end

  // Load data register: updated only by load commits; errors clear it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= '0;
    end else if (commit) begin
      if (accErr) begin
        rdata_o <= '0;
      end else if (!we_i) begin
        rdata_o <= loadData;
      end
    end
  end

  // RAM write port: read-modify-write of the addressed word on store commit
  always_ff @(posedge clk) begin
    if (commit && we_i && !accErr) begin
      mem[wordIdx] <= newWord;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic errQ;

  // Error flag is live only during the DONE cycle of a faulting access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errQ <= 1'b0;
    end else begin
      errQ <= commit & accErr;
    end
  end

  assign err_o = errQ;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYC=2 and WAIT_CYC=0) checked
// against a byte-addressed reference memory model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int AW    = 10;
  localparam int NBYTE = 1 << (AW + 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic        sign  [2];
  logic [1:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        err   [2];

  int          vectors     = 0;
  int          miscompares = 0;
  logic        inDone [2];
  logic [31:0] lastR  [2];
  logic [7:0]  mdl [int];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(2)) dutA (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .sign_i(sign[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
    .rdata_o(rdata[0]), .stall_o(stall[0]), .err_o(err[0])
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dutB (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .sign_i(sign[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
    .rdata_o(rdata[1]), .stall_o(stall[1]), .err_o(err[1])
  );

  function automatic int waitOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int nBytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic modelErr(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int keyOf(input int d, input int byteAddr);
    return d * NBYTE + (byteAddr % NBYTE);
  endfunction

  task automatic modelStore(input int d, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
    int n = nBytes(sz);
    int base = (int'(a) / n) * n;
    for (int i = 0; i < n; i++) mdl[keyOf(d, base + i)] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] modelLoad(input int d, input logic [1:0] sz, input logic sg,
                                            input logic [31:0] a);
    int n = nBytes(sz);
    int base = (int'(a) / n) * n;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[keyOf(d, base + i)];
    if (n < 4 && sg && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; returns while the DUT sits in DONE with req held
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
    int cnt;
    logic e;
    req[d] = 1'b1; we[d] = w; size[d] = sz; sign[d] = sg; addr[d] = a; wdata[d] = wd;
    if (inDone[d]) @(negedge clk);
    #1;
    chk("err_before_done", {31'd0, err[d]}, 32'd0);
    cnt = 0;
    while (stall[d] && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(cnt), 32'(waitOf(d) + 1));
    e = modelErr(sz, a);
    chk("err_done", {31'd0, err[d]}, {31'd0, e});
    if (e) lastR[d] = '0;
    else if (w) modelStore(d, sz, a, wd);
    else lastR[d] = modelLoad(d, sz, sg, a);
    chk("rdata", rdata[d], lastR[d]);
    obs = rdata[d];
    inDone[d] = 1'b1;
  endtask

  task automatic idle(input int d);
    req[d] = 1'b0;
    @(negedge clk);
    #1;
    chk("err_idle", {31'd0, err[d]}, 32'd0);
    chk("stall_idle", {31'd0, stall[d]}, 32'd0);
    inDone[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  sz;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; sign[d] = 0; size[d] = 0; addr[d] = 0; wdata[d] = 0;
      inDone[d] = 0; lastR[d] = 0;
    end

    // Reset: outputs cleared, stall forced low even with a pending request
    rst = 1'b1;
    repeat (2) @(negedge clk);
    req[0] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_err", {31'd0, err[d]}, 32'd0);
      chk("rst_stall", {31'd0, stall[d]}, 32'd0);
    end
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Word store / load round trip
    access(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, r);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, r);
    chk("word_readback", r, 32'hDEAD_BEEF);
    idle(0);

    // Byte merge into lane 3 and byte/word extraction
    access(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, r);
    access(0, 1, 2'b00, 0, 32'h13, 32'h1234_5680, r);
    access(0, 0, 2'b00, 1, 32'h13, 32'h0, r);
    chk("byte_signed", r, 32'hFFFF_FF80);
    access(0, 0, 2'b00, 0, 32'h13, 32'h0, r);
    chk("byte_unsigned", r, 32'h0000_0080);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, r);
    chk("byte_merged_word", r, 32'h8022_3344);
    idle(0);

    // Upper half extraction
    access(0, 1, 2'b10, 0, 32'h10, 32'hABCD_1234, r);
    access(0, 0, 2'b01, 0, 32'h12, 32'h0, r);
    chk("half_unsigned", r, 32'h0000_ABCD);
    access(0, 0, 2'b01, 1, 32'h12, 32'h0, r);
    chk("half_signed", r, 32'hFFFF_ABCD);
    idle(0);

    // Misaligned word store
    access(0, 1, 2'b10, 0, 32'h11, 32'h5566_7788, r);
    idle(0);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, r);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misaligned_no_write", r, 32'hABCD_1234);
`else
    chk("misaligned_forced", r, 32'h5566_7788);
`endif
    idle(0);

    // Flush in WAIT: no write, no rdata change
    access(0, 1, 2'b10, 0, 32'h20, 32'h1234_5678, r);
    idle(0);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h20; wdata[0] = 32'h5;
    @(negedge clk);
    #1;
    chk("abort_stall_wait", {31'd0, stall[0]}, 32'd1);
    req[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_rdata_held", rdata[0], lastR[0]);
    access(0, 0, 2'b10, 0, 32'h20, 32'h0, r);
    chk("abort_old_value", r, 32'h1234_5678);
    idle(0);

    // Reset during WAIT
    req[0] = 1'b1; we[0] = 1'b0; size[0] = 2'b10; addr[0] = 32'h20;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall[0]}, 32'd0);
    chk("rst_mid_rdata", rdata[0], 32'd0);
    lastR[0] = '0; lastR[1] = '0;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    access(0, 0, 2'b10, 0, 32'h20, 32'h0, r);
    chk("after_rst_load", r, 32'h1234_5678);
    idle(0);

    // Zero wait states: back-to-back loads
    access(1, 1, 2'b10, 0, 32'h0, 32'hA5A5_0001, r);
    access(1, 1, 2'b10, 0, 32'h4, 32'h5A5A_0002, r);
    idle(1);
    access(1, 0, 2'b10, 0, 32'h0, 32'h0, r);
    chk("w0_load0", r, 32'hA5A5_0001);
    access(1, 0, 2'b10, 0, 32'h4, 32'h0, r);
    chk("w0_load4", r, 32'h5A5A_0002);
    idle(1);

    // Randomized traffic over preloaded regions
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) access(d, 1, 2'b10, 0, 32'h100 + 32'(4*i), $urandom, r);
      idle(d);
      for (int i = 0; i < 50; i++) begin
        sz = 2'($urandom_range(0, 3));
        access(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               32'h100 + 32'($urandom_range(0, 63)), $urandom, r);
        if ($urandom_range(0, 2) == 0) idle(d);
      end
      idle(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
